// File: rtl/equiv_sweep_checker.sv
// equiv_sweep_checker
// Response-side checker for an exhaustive equivalence sweep. Steps through
// every N_IN-bit input vector, holds each one for SETTLE cycles, then samples
// the two circuit outputs and the comparator output. A vector mismatches when
// the circuits disagree or when the comparator does not report their
// equality. Mismatches are counted, the lowest failing vector is latched, and
// pass/fail is reported once the sweep completes.
module equiv_sweep_checker #(
    parameter int N_IN   = 5,
    parameter int SETTLE = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic [N_IN-1:0] vec,
    input  logic            out1,
    input  logic            out2,
    input  logic            eq,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic            fail_valid,
    output logic [N_IN-1:0] first_fail
);

    // Hold counter is at least one bit wide so SETTLE=1 builds stay legal.
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(SETTLE - 1);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
    localparam logic [N_IN-1:0] VEC_ONE  = N_IN'(1);
    localparam logic [N_IN-1:0] VEC_LAST = {N_IN{1'b1}};
    localparam logic [N_IN:0]   ERR_ONE  = (N_IN + 1)'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [CW-1:0]   cnt;
    logic            sample;
    logic            mismatch;

    assign sample   = (state == RUN) && (cnt == CNT_LAST);
    assign mismatch = (out1 != out2) || (eq != (out1 == out2));

    assign busy = (state == RUN);
    assign done = (state == DONE);
    assign pass = (state == DONE) && (err_count == '0);

    // State register; reset abandons any sweep in progress.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: start is only honoured outside a running sweep.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: if (start) next_state = RUN;
            RUN:  if (sample && (vec == VEC_LAST)) next_state = DONE;
            DONE: if (start) next_state = RUN;
            default: next_state = IDLE;
        endcase
    end

    // Sweep datapath: vector stepping, hold counter and result capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vec        <= '0;
            cnt        <= '0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            first_fail <= '0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        vec        <= '0;
                        cnt        <= '0;
                        err_count  <= '0;
                        fail_valid <= 1'b0;
                        first_fail <= '0;
                    end
                end
                RUN: begin
                    if (sample) begin
                        cnt <= '0;
                        vec <= vec + VEC_ONE;
                        if (mismatch) begin
                            err_count <= err_count + ERR_ONE;
                            if (!fail_valid) begin
                                fail_valid <= 1'b1;
                                first_fail <= vec;
                            end
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
